// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock ratio monitor: FSM encodings, default
// half-period/lock constants and the interval-timer width helper.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_t;

   localparam int DEF_HP_2F    = 2;
   localparam int DEF_HP_F     = 4;
   localparam int DEF_LOCK_CNT = 4;
   localparam int DEF_ERR_W    = 8;

   // The timer counts 0..HP+1, so it needs room for HP+2 distinct values.
   function automatic int timer_width(input int hp);
      return $clog2(hp + 2);
   endfunction

endpackage

// File: rtl/clk_ratio_monitor_if.sv
// Status/stimulus bundle between the clock divider under test, the monitor
// and the test/control logic.
interface clk_ratio_monitor_if
   import clk_mon_pkg::*;
#(
   parameter int ERR_W = DEF_ERR_W
);

   logic             clk_2f_in;
   logic             clk_f_in;
   logic             locked;
   logic             lock_lost;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;

   modport master (
      output clk_2f_in,
      output clk_f_in,
      input  locked,
      input  lock_lost,
      input  err_pulse,
      input  err_count
   );

   modport slave (
      input  clk_2f_in,
      input  clk_f_in,
      output locked,
      output lock_lost,
      output err_pulse,
      output err_count
   );

endinterface

// File: rtl/clk_edge_timer.sv
// Samples one divided clock as data, detects its edges and checks the spacing
// between them. CLK_MON_SYNC_EN adds a 2-flop synchronizer ahead of the sampler.
module clk_edge_timer
   import clk_mon_pkg::*;
#(
   parameter int HP = DEF_HP_2F
)(
   input  logic clk_8f,
   input  logic reset,
   input  logic clk_in,
   output logic edge_det,
   output logic armed,
   output logic per_err
);

   localparam int            TW    = timer_width(HP);
   localparam logic [TW-1:0] HP_V  = TW'(HP);
   localparam logic [TW-1:0] SAT_V = TW'(HP + 1);

   logic          sample_d;
   logic          s_clk;
   logic          p_clk;
   logic [TW-1:0] timer;

`ifdef CLK_MON_SYNC_EN
   logic sync_1;
   logic sync_2;

   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= clk_in;
         sync_2 <= sync_1;
      end
   end

   assign sample_d = sync_2;
`else
   assign sample_d = clk_in;
`endif

   // The timer stays parked at zero until the first edge arms it, so a
   // generator that starts with both clocks low never raises an error.
   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         s_clk <= 1'b0;
         p_clk <= 1'b0;
         timer <= '0;
         armed <= 1'b0;
      end else begin
         s_clk <= sample_d;
         p_clk <= s_clk;
         if (edge_det) begin
            timer <= TW'(1);
            armed <= 1'b1;
         end else if (armed && (timer != SAT_V)) begin
            timer <= timer + TW'(1);
         end
      end
   end

   assign edge_det = s_clk ^ p_clk;

   // A stall is flagged only on the HP -> HP+1 step, so it fires once per stall.
   assign per_err = armed && (edge_det ? (timer != HP_V) : (timer == HP_V));

endmodule

// File: rtl/clk_ratio_monitor.sv
// Verifies that clk_2f/clk_f keep their /4 and /8 ratio and phase against clk_8f.
// Define CLK_MON_SYNC_EN when the divided clocks come from a foreign domain.
module clk_ratio_monitor
   import clk_mon_pkg::*;
#(
   parameter int HP_2F    = DEF_HP_2F,
   parameter int HP_F     = DEF_HP_F,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   parameter int ERR_W    = DEF_ERR_W
)(
   input logic                clk_8f,
   input logic                reset,
   clk_ratio_monitor_if.slave mon
);

   localparam int GW = $clog2(LOCK_CNT + 1);

   logic             edge_2f;
   logic             edge_f;
   logic             armed_2f;
   logic             armed_f;
   logic             per_err_2f;
   logic             per_err_f;
   logic             phase_err;
   logic             any_err;

   mon_state_t       state;
   mon_state_t       state_nxt;
   logic [GW-1:0]    good_cnt;
   logic [GW-1:0]    good_cnt_nxt;
   logic             locked_q;
   logic             locked_nxt;
   logic             lock_lost_q;
   logic             lock_lost_nxt;
   logic             err_pulse_q;
   logic [ERR_W-1:0] err_count_q;

   clk_edge_timer #(.HP(HP_2F)) u_timer_2f (
      .clk_8f   (clk_8f),
      .reset    (reset),
      .clk_in   (mon.clk_2f_in),
      .edge_det (edge_2f),
      .armed    (armed_2f),
      .per_err  (per_err_2f)
   );

   clk_edge_timer #(.HP(HP_F)) u_timer_f (
      .clk_8f   (clk_8f),
      .reset    (reset),
      .clk_in   (mon.clk_f_in),
      .edge_det (edge_f),
      .armed    (armed_f),
      .per_err  (per_err_f)
   );

   // Every clk_f edge must coincide with a clk_2f edge once both are tracked.
   assign phase_err = armed_f && armed_2f && edge_f && !edge_2f;
   assign any_err   = per_err_2f | per_err_f | phase_err;

   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         state       <= IDLE;
         good_cnt    <= '0;
         locked_q    <= 1'b0;
         lock_lost_q <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state       <= state_nxt;
         good_cnt    <= good_cnt_nxt;
         locked_q    <= locked_nxt;
         lock_lost_q <= lock_lost_nxt;
         err_pulse_q <= any_err;
         if (err_pulse_q && (err_count_q != '1)) begin
            err_count_q <= err_count_q + ERR_W'(1);
         end
      end
   end

   // Errors are tested before edge counting so they win over lock completion.
   always_comb begin
      state_nxt     = state;
      good_cnt_nxt  = good_cnt;
      locked_nxt    = 1'b0;
      lock_lost_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (edge_f) begin
               state_nxt    = ACQUIRE;
               good_cnt_nxt = '0;
            end
         end
         ACQUIRE: begin
            if (any_err) begin
               good_cnt_nxt = '0;
            end else if (edge_f) begin
               if (good_cnt == GW'(LOCK_CNT - 1)) begin
                  state_nxt    = LOCKED;
                  good_cnt_nxt = '0;
                  locked_nxt   = 1'b1;
               end else begin
                  good_cnt_nxt = good_cnt + GW'(1);
               end
            end
         end
         LOCKED: begin
            if (any_err) begin
               state_nxt     = ACQUIRE;
               good_cnt_nxt  = '0;
               lock_lost_nxt = 1'b1;
            end else begin
               locked_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt    = IDLE;
            good_cnt_nxt = '0;
         end
      endcase
   end

   assign mon.locked    = locked_q;
   assign mon.lock_lost = lock_lost_q;
   assign mon.err_pulse = err_pulse_q;
   assign mon.err_count = err_count_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor: ideal divider, glitch, stall, phase
// shift, counter saturation and mid-lock reset. Honours CLK_MON_SYNC_EN.
module tb_clk_ratio_monitor;
   import clk_mon_pkg::*;

`ifdef CLK_MON_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk_8f = 1'b0;
   logic reset  = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   ph     = 0;

   int   err_rises     = 0;
   int   lost_cycles   = 0;
   int   locked_cycles = 0;
   logic err_prev      = 1'b0;

   clk_ratio_monitor_if #(.ERR_W(8)) bus ();

   clk_ratio_monitor #(
      .HP_2F    (2),
      .HP_F     (4),
      .LOCK_CNT (4),
      .ERR_W    (8)
   ) dut (
      .clk_8f (clk_8f),
      .reset  (reset),
      .mon    (bus.slave)
   );

   always #5 clk_8f = ~clk_8f;

   always @(negedge clk_8f) begin
      if (bus.err_pulse && !err_prev) err_rises++;
      if (bus.lock_lost) lost_cycles++;
      if (bus.locked) locked_cycles++;
      err_prev = bus.err_pulse;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic v2f, input logic vf);
      bus.clk_2f_in = v2f;
      bus.clk_f_in  = vf;
      @(posedge clk_8f);
      #1;
   endtask

   function automatic logic ideal_2f(input int n);
      return n[1];
   endfunction

   function automatic logic ideal_f(input int n);
      return n[2];
   endfunction

   task automatic run_ideal(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         apply_stimulus(ideal_2f(ph), ideal_f(ph));
         ph++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0);
   endtask

   initial begin
      int e0;
      int l0;
      int c0;
      int k0;
      int waited;

      bus.clk_2f_in = 1'b0;
      bus.clk_f_in  = 1'b0;

      // Reset state
      do_reset();
      check_output("rst_locked",    bus.locked,    0);
      check_output("rst_lock_lost", bus.lock_lost, 0);
      check_output("rst_err_pulse", bus.err_pulse, 0);
      check_output("rst_err_count", bus.err_count, 0);
      reset = 1'b1;
      ph = 0;

      // Ideal divider: first clk_f edge at ph 4, good edges at 8,12,16,20
      run_ideal(20);
      check_output("s1_not_yet_locked", bus.locked, 0);
      run_ideal(8);
      check_output("s1_locked",    bus.locked,    1);
      check_output("s1_err_count", bus.err_count, 0);

      // clk_2f held one extra cycle at a clk_f edge, then back on schedule
      run_ideal(4);
      e0 = err_rises;
      l0 = lost_cycles;
      apply_stimulus(ideal_2f(ph - 1), ideal_f(ph));
      ph++;
      run_ideal(7);
      check_output("s2_locked_drop",   bus.locked, 0);
      check_output("s2_lock_lost_one", lost_cycles - l0, 1);
      check_output("s2_err_pulse_one", err_rises - e0, 1);
      run_ideal(16);
      check_output("s2_relocked", bus.locked, 1);

      // clk_f frozen high while locked
      e0 = err_rises;
      l0 = lost_cycles;
      c0 = int'(bus.err_count);
      for (int i = 0; i < 24; i++) begin
         apply_stimulus(ideal_2f(ph), 1'b1);
         ph++;
      end
      check_output("s3_err_count_one", int'(bus.err_count) - c0, 1);
      check_output("s3_err_pulse_one", err_rises - e0, 1);
      check_output("s3_locked",        bus.locked, 0);
      check_output("s3_lock_lost_one", lost_cycles - l0, 1);
      check_output("s3_quiet",         bus.err_pulse, 0);

      // Reset while locked
      do_reset();
      reset = 1'b1;
      ph = 0;
      run_ideal(28);
      check_output("s6_pre_locked", bus.locked, 1);
      l0 = lost_cycles;
      reset = 1'b0;
      apply_stimulus(ideal_2f(ph), ideal_f(ph));
      ph++;
      check_output("s6_locked",    bus.locked,    0);
      check_output("s6_lock_lost", bus.lock_lost, 0);
      check_output("s6_err_pulse", bus.err_pulse, 0);
      check_output("s6_err_count", bus.err_count, 0);
      check_output("s6_state",     dut.state,     IDLE);
      reset = 1'b1;
      run_ideal(4);
      check_output("s6_no_instant_lock", bus.locked, 0);
      waited = 0;
      while (!bus.locked && waited < 64) begin
         run_ideal(1);
         waited++;
      end
      check_output("s6_relock",        bus.locked, 1);
      check_output("s6_no_lock_lost",  lost_cycles - l0, 0);

      // clk_f delayed by one cycle: edges at ph 5,9,..., phase error from 9 on
      do_reset();
      reset = 1'b1;
      ph = 0;
      k0 = locked_cycles;
      for (int i = 0; i < 42; i++) begin
         apply_stimulus(ideal_2f(ph), (ph == 0) ? 1'b0 : ideal_f(ph - 1));
         ph++;
      end
      check_output("s4_never_locked", locked_cycles - k0, 0);
      check_output("s4_err_count",    bus.err_count, 8);

      // clk_2f toggling every cycle: one error per cycle after the arming edge
      do_reset();
      reset = 1'b1;
      for (int i = 0; i < 100; i++) apply_stimulus(~i[0], 1'b0);
      check_output("s5_err_count_mid", bus.err_count, 97 - LAT);
      for (int i = 100; i < 400; i++) apply_stimulus(~i[0], 1'b0);
      check_output("s5_err_count_sat", bus.err_count, 255);
      check_output("s5_err_pulse_on",  bus.err_pulse, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
